prio_grant_ctrl: RTL
====================

PRIO_GRANT_CTRL -- requirements
Module: prio_grant_ctrl

Interface
REQ-001: The module SHALL have parameter STABLE, default 2, giving the number of consecutive identical valid code samples required before a grant (legal range 2..15).
REQ-002: The module SHALL have parameter TIMEOUT, default 255, giving the maximum number of GRANT cycles before an abort (legal range 2..255).
REQ-003: The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004: The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005: The module SHALL have port code, input, 4 bits, produced by the upstream 8-to-3 priority encoder: code[3] = request valid, code[2:0] = winning index, 7 = highest priority.
REQ-006: The module SHALL have port ack, input, 1 bit: the serviced source acknowledges the grant.
REQ-007: The module SHALL have port req, output, 1 bit: grant active.
REQ-008: The module SHALL have port grant_idx, output, 3 bits: the granted index.
REQ-009: The module SHALL have port grant_n, output, 8 bits: active-low one-hot grant, with the same polarity as the encoder inputs.
REQ-010: The module SHALL have port timeout, output, 1 bit: one-cycle abort pulse.
REQ-011: The module SHALL have port busy, output, 1 bit: asserted whenever the controller is not idle.

Function
REQ-012: The controller SHALL be a four-state FSM with states IDLE, QUAL, GRANT and RELEASE; all outputs SHALL be registered or decoded only from registered state.
REQ-013: In IDLE, on a clock edge with code[3]=1, the controller SHALL capture cand<=code[2:0] and stab_cnt<=1, and go to QUAL; otherwise it SHALL stay in IDLE.
REQ-014: In QUAL, each edge with code=={1,cand} SHALL increment stab_cnt; the edge where the count reaches STABLE SHALL move to GRANT, set grant_idx<=cand and clear the timer.
REQ-015: In QUAL, code[3]=0 SHALL return the FSM to IDLE; a valid code with a different index SHALL reload cand<=code[2:0] and set stab_cnt<=1, staying in QUAL.
REQ-016: req SHALL be 1 exactly while state==GRANT; grant_n SHALL equal ~(8'b1<<grant_idx) in GRANT and 8'hFF in every other state.
REQ-017: In GRANT, the timer SHALL increment every cycle; ack=1 SHALL move the FSM to RELEASE.
REQ-018: If ack=0 while timer==TIMEOUT-1, the FSM SHALL move to RELEASE and assert timeout for exactly one cycle, coincident with the first RELEASE cycle; req therefore lasts at most TIMEOUT cycles.
REQ-019: ack=1 on the final timer cycle SHALL take priority over the abort: no timeout pulse.
REQ-020: In RELEASE, the FSM SHALL stay until code[3]=0 or code[2:0]!=grant_idx, then go to IDLE; a new request SHALL then requalify from scratch.
REQ-021: ack in IDLE, QUAL or RELEASE SHALL be ignored.
REQ-022: busy SHALL be 0 in IDLE and 1 in QUAL, GRANT and RELEASE.
REQ-023: grant_idx SHALL hold its last granted value outside GRANT.
REQ-024: The code input SHALL be registered once before use; all latency figures below include this stage.

Reset
REQ-025: rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, req=0, grant_idx=0, grant_n=8'hFF, timeout=0, busy=0, and clear the timer, stab_cnt and cand.
REQ-026: Deassertion of rst_n SHALL take effect on the next rising clk edge; reset asserted mid-GRANT SHALL drop req without producing a timeout pulse.

Verification
REQ-027: Directed test, normal grant (STABLE=2): code=4'b1101 held -> req=1, grant_idx=5 and grant_n=8'b11011111 after the 3rd edge (1 input-register edge + 2 qualifying edges); ack=1 for one cycle -> req=0 at the next edge; code=0 -> busy=0 one edge later.
REQ-028: Directed test, glitch rejection: code=1101 for 1 cycle, then 1110 for 2 cycles -> grant_idx=6, and index 5 is never granted (grant_n never equals 8'b11011111).
REQ-029: Directed test, timeout (TIMEOUT=4): no ack -> req high for exactly 4 cycles, then timeout=1 for 1 cycle; busy stays 1 until code[3]=0.
REQ-030: Directed test, ack/timeout collision: ack=1 on the 4th GRANT cycle with TIMEOUT=4 -> RELEASE entered and timeout stays 0.
REQ-031: Directed test, RELEASE exit on index change: in RELEASE with grant_idx=5, code changes to 1111 -> IDLE, then grant_idx=7 after requalification; ack pulses in IDLE produce no output change.
REQ-032: Directed test, asynchronous reset: rst_n pulled low mid-GRANT between clock edges -> req=0 and grant_n=8'hFF within the same cycle; timeout stays 0.

Source files
------------

// File: rtl/prio_grant_ctrl.sv
// prio_grant_ctrl
//   Qualifies a priority-encoder code (it must be stable for STABLE samples),
//   then grants the winning index until the source acknowledges or the
//   grant times out, and waits for the request to drop before re-arming.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   code[3:0] : {valid, index[2:0]} from the upstream 8-to-3 priority encoder
//   ack       : acknowledge from the serviced source (only honoured in GRANT)
//   req       : grant active
//   grant_idx : granted index, held after the grant ends
//   grant_n   : active-low one-hot grant (8'hFF when not granting)
//   timeout   : one-cycle pulse when a grant is aborted for lack of ack
//   busy      : controller not idle
module prio_grant_ctrl #(
  parameter int STABLE  = 2,   // 2..15
  parameter int TIMEOUT = 255  // 2..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] code,
  input  logic       ack,
  output logic       req,
  output logic [2:0] grant_idx,
  output logic [7:0] grant_n,
  output logic       timeout,
  output logic       busy
);

  localparam logic [3:0] LP_STABLE   = 4'(STABLE);
  localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t     r_state;
  logic [3:0] r_code;
  logic [2:0] r_cand;
  logic [3:0] r_stab_cnt;
  logic [7:0] r_timer;
  logic [2:0] r_grant_idx;
  logic       r_timeout;

  // Input stage: the encoder output is sampled once before the FSM looks at it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_code <= 4'd0;
    else        r_code <= code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cand      <= 3'd0;
      r_stab_cnt  <= 4'd0;
      r_timer     <= 8'd0;
      r_grant_idx <= 3'd0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_code[3]) begin
            r_cand     <= r_code[2:0];
            r_stab_cnt <= 4'd1;
            r_state    <= QUAL;
          end
        end
        QUAL: begin
          if (!r_code[3]) begin
            r_state <= IDLE;
          end else if (r_code[2:0] != r_cand) begin
            // Winner changed before settling: restart qualification on it.
            r_cand     <= r_code[2:0];
            r_stab_cnt <= 4'd1;
          end else if (r_stab_cnt + 4'd1 == LP_STABLE) begin
            r_stab_cnt  <= r_stab_cnt + 4'd1;
            r_grant_idx <= r_cand;
            r_timer     <= 8'd0;
            r_state     <= GRANT;
          end else begin
            r_stab_cnt <= r_stab_cnt + 4'd1;
          end
        end
        GRANT: begin
          // ack wins over the abort on the final timer cycle.
          if (ack) begin
            r_state <= RELEASE;
          end else if (r_timer == LP_TMO_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= RELEASE;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        RELEASE: begin
          // Wait for the granted request to go away so it is not re-granted.
          if (!r_code[3] || (r_code[2:0] != r_grant_idx))
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs decoded purely from registered state.
  logic w_granting;
  assign w_granting = (r_state == GRANT);

  assign req       = w_granting;
  assign grant_idx = r_grant_idx;
  assign grant_n   = w_granting ? ~(8'd1 << r_grant_idx) : 8'hFF;
  assign timeout   = r_timeout;
  assign busy      = (r_state != IDLE);

endmodule
